// File: rtl/accum_share_sched.sv
// accum_share_sched
//   Shares one accumulate engine between NUM_REQ requesters using round-robin arbitration.
//   Each requester owns a private accumulator context held inside this block.
//   One op flows IDLE (arbitrate/accept) -> EXEC (add, update context) -> RESP (hand off result).

module accum_share_sched #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]      req_data,
  input  logic [NUM_REQ-1:0]            req_bypass,
  input  logic [NUM_REQ-1:0]            req_clear,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
  output logic [WIDTH-1:0]              rsp_data,
  output logic [WIDTH-1:0]              rsp_accum,
  output logic                          busy
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   gnt_q, gnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             bypass_q, bypass_d;
  logic             clear_q, clear_d;
  logic [WIDTH-1:0] ctx_q [NUM_REQ];
  logic [WIDTH-1:0] ctx_d [NUM_REQ];
  logic             rspValid_q, rspValid_d;
  logic [IDW-1:0]   rspId_q, rspId_d;
  logic [WIDTH-1:0] rspData_q, rspData_d;
  logic [WIDTH-1:0] rspAccum_q, rspAccum_d;

  logic             grantFound;
  logic [IDW-1:0]   grantIdx;
  logic [WIDTH-1:0] ctxBase;
  logic [WIDTH-1:0] sum;

  // Round-robin search: the first valid requester starting at ptr wins.
  always_comb begin
    int idx;
    logic [IDW-1:0] cand;
    grantFound = 1'b0;
    grantIdx   = '0;
    idx        = 0;
    cand       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      cand = IDW'(idx);
      if (!grantFound && req_valid[cand]) begin
        grantFound = 1'b1;
        grantIdx   = cand;
      end
    end
  end

  // One-hot accept, only while idle and never while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == IDLE) && grantFound) begin
      req_ready[grantIdx] = 1'b1;
    end
  end

  // Shared adder: a clear makes the context look like zero, the carry out is dropped.
  always_comb begin
    ctxBase = clear_q ? '0 : ctx_q[gnt_q];
    sum     = ctxBase + data_q;
  end

  // Next-state and datapath updates for the IDLE -> EXEC -> RESP sequence.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    data_d     = data_q;
    bypass_d   = bypass_q;
    clear_d    = clear_q;
    ctx_d      = ctx_q;
    rspValid_d = rspValid_q;
    rspId_d    = rspId_q;
    rspData_d  = rspData_q;
    rspAccum_d = rspAccum_q;
    unique case (state_q)
      IDLE: begin
        if (grantFound) begin
          gnt_d    = grantIdx;
          data_d   = req_data[grantIdx*WIDTH +: WIDTH];
          bypass_d = req_bypass[grantIdx];
          clear_d  = req_clear[grantIdx];
          state_d  = EXEC;
        end
      end
      EXEC: begin
        ctx_d[gnt_q] = sum;
        rspAccum_d   = sum;
        rspData_d    = bypass_q ? data_q : sum;
        rspId_d      = gnt_q;
        rspValid_d   = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (rspValid_q && rsp_ready) begin
          rspValid_d = 1'b0;
          ptr_d      = (gnt_q == IDW'(NUM_REQ - 1)) ? '0 : gnt_q + IDW'(1);
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, contexts and response registers; reset drops any in-flight op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gnt_q      <= '0;
      data_q     <= '0;
      bypass_q   <= 1'b0;
      clear_q    <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        ctx_q[i] <= '0;
      end
      rspValid_q <= 1'b0;
      rspId_q    <= '0;
      rspData_q  <= '0;
      rspAccum_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      data_q     <= data_d;
      bypass_q   <= bypass_d;
      clear_q    <= clear_d;
      ctx_q      <= ctx_d;
      rspValid_q <= rspValid_d;
      rspId_q    <= rspId_d;
      rspData_q  <= rspData_d;
      rspAccum_q <= rspAccum_d;
    end
  end

  assign rsp_valid = rspValid_q;
  assign rsp_id    = rspId_q;
  assign rsp_data  = rspData_q;
  assign rsp_accum = rspAccum_q;
  assign busy      = (state_q != IDLE);

  // Accept is at most one-hot and only ever offered from IDLE.
  always @(posedge clk) begin
    if (rst_n) begin
      assert ($onehot0(req_ready));
      assert ((state_q == IDLE) || (req_ready == '0));
    end
  end

endmodule

// File: tb/tb_accum_share_sched.sv
// tb_accum_share_sched
//   Directed bench for the shared accumulate scheduler with hand-computed expectations.

module tb_accum_share_sched;

  localparam int NUM_REQ = 2;
  localparam int WIDTH   = 32;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_bypass;
  logic [NUM_REQ-1:0]       req_clear;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [0:0]               rsp_id;
  logic [WIDTH-1:0]         rsp_data;
  logic [WIDTH-1:0]         rsp_accum;
  logic                     busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [0:0]       gotId   [8];
  logic [WIDTH-1:0] gotData [8];
  logic [WIDTH-1:0] gotAcc  [8];

  accum_share_sched #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_bypass (req_bypass),
    .req_clear  (req_clear),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_accum  (rsp_accum),
    .busy       (busy)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to measure accept/response spacing.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic applyReset();
    rst_n      = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    req_bypass = '0;
    req_clear  = '0;
    rsp_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic doOp(input int id, input logic [WIDTH-1:0] d, input logic byp, input logic clr,
                      output logic [WIDTH-1:0] rdata, output logic [WIDTH-1:0] racc,
                      output logic [0:0] rid, output int accCyc, output int rspCyc,
                      output bit timeout);
    bit got;
    got = 0; timeout = 1; rdata = '0; racc = '0; rid = '0; accCyc = 0; rspCyc = 0;
    rsp_ready = 1'b1;
    req_data[id*WIDTH +: WIDTH] = d;
    req_bypass[id] = byp;
    req_clear[id]  = clr;
    req_valid[id]  = 1'b1;
    for (int n = 0; n < 20 && !got; n++) begin
      #1;
      if (req_ready[id]) got = 1;
      @(posedge clk);
      #1;
    end
    accCyc = cyc;
    req_valid[id]  = 1'b0;
    req_bypass[id] = 1'b0;
    req_clear[id]  = 1'b0;
    if (!got) return;
    for (int n = 0; n < 20; n++) begin
      if (rsp_valid) begin
        rdata = rsp_data; racc = rsp_accum; rid = rsp_id; rspCyc = cyc; timeout = 0;
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic collectRsp(input int num, output bit timeout);
    int k;
    k = 0;
    for (int n = 0; n < 100 && k < num; n++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) begin
        gotId[k] = rsp_id; gotData[k] = rsp_data; gotAcc[k] = rsp_accum;
        k++;
        if (k == num) req_valid = '0;
      end
    end
    timeout = (k < num);
    req_valid = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_data = '0; req_bypass = '0; req_clear = '0; rsp_ready = 1'b1;
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("[TB] FAIL reset_req_ready: got %b expected 00", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (rsp_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_rsp_data: got %h expected 0", rsp_data); end
    checks++; if (rsp_accum !== 32'd0) begin errors++; $display("[TB] FAIL reset_rsp_accum: got %h expected 0", rsp_accum); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_id: got %b expected 0", rsp_id); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req_ready !== 2'b00 || busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_held: req_ready %b busy %b expected 00 0", req_ready, busy); end
    req_valid = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_single_accum();
    logic [WIDTH-1:0] ops [3];
    logic [WIDTH-1:0] expData [3];
    logic [WIDTH-1:0] rd, ra;
    logic [0:0] ri;
    int ac, rc, prevAc;
    bit to;
    ops = '{32'd5, 32'd10, 32'd15};
    expData = '{32'd5, 32'd15, 32'd30};
    prevAc = 0;
    for (int i = 0; i < 3; i++) begin
      doOp(0, ops[i], 1'b0, 1'b0, rd, ra, ri, ac, rc, to);
      checks++;
      if (to) begin
        errors++; $display("[TB] FAIL single_timeout[%0d]: no response within bound, expected one", i);
      end else begin
        checks++; if (rd !== expData[i]) begin errors++; $display("[TB] FAIL single_data[%0d]: got %0d expected %0d", i, rd, expData[i]); end
        checks++; if (ri !== 1'b0) begin errors++; $display("[TB] FAIL single_id[%0d]: got %0d expected 0", i, ri); end
        checks++; if (rc - ac !== 1) begin errors++; $display("[TB] FAIL single_latency[%0d]: got %0d expected 1 cycle after accept", i, rc - ac); end
        if (i > 0) begin
          checks++; if (ac - prevAc !== 3) begin errors++; $display("[TB] FAIL single_spacing[%0d]: got %0d expected 3", i, ac - prevAc); end
        end
      end
      prevAc = ac;
    end
  endtask

  task automatic test_round_robin();
    logic [0:0] expId [4];
    logic [WIDTH-1:0] expAcc [4];
    bit to;
    expId  = '{1'b0, 1'b1, 1'b0, 1'b1};
    expAcc = '{32'd1, 32'd1, 32'd2, 32'd2};
    applyReset();
    req_data = {32'd1, 32'd1};
    req_valid = 2'b11;
    collectRsp(4, to);
    checks++;
    if (to) begin
      errors++; $display("[TB] FAIL rr_timeout: fewer than 4 responses, expected 4");
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (gotId[i] !== expId[i]) begin errors++; $display("[TB] FAIL rr_id[%0d]: got %0d expected %0d", i, gotId[i], expId[i]); end
        checks++; if (gotAcc[i] !== expAcc[i] || gotData[i] !== expAcc[i]) begin errors++; $display("[TB] FAIL rr_acc[%0d]: got acc %0d data %0d expected %0d", i, gotAcc[i], gotData[i], expAcc[i]); end
      end
    end
  endtask

  task automatic test_bypass();
    logic [WIDTH-1:0] rd, ra;
    logic [0:0] ri;
    int ac, rc;
    bit to;
    doOp(1, 32'd30, 1'b0, 1'b1, rd, ra, ri, ac, rc, to);
    checks++; if (to || ra !== 32'd30) begin errors++; $display("[TB] FAIL bypass_setup: got acc %0d timeout %0d expected 30", ra, to); end
    doOp(1, 32'd7, 1'b1, 1'b0, rd, ra, ri, ac, rc, to);
    checks++; if (to || rd !== 32'd7) begin errors++; $display("[TB] FAIL bypass_data: got %0d timeout %0d expected 7", rd, to); end
    checks++; if (ra !== 32'd37) begin errors++; $display("[TB] FAIL bypass_accum: got %0d expected 37", ra); end
    checks++; if (ri !== 1'b1) begin errors++; $display("[TB] FAIL bypass_id: got %0d expected 1", ri); end
    doOp(1, 32'd1, 1'b0, 1'b0, rd, ra, ri, ac, rc, to);
    checks++; if (to || rd !== 32'd38 || ra !== 32'd38) begin errors++; $display("[TB] FAIL bypass_after: got data %0d acc %0d expected 38 38", rd, ra); end
  endtask

  task automatic test_clear_wrap();
    logic [WIDTH-1:0] rd, ra;
    logic [0:0] ri;
    int ac, rc;
    bit to;
    doOp(0, 32'hFFFF_FFFF, 1'b0, 1'b1, rd, ra, ri, ac, rc, to);
    checks++; if (to || rd !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL clear_data: got %h timeout %0d expected ffffffff", rd, to); end
    doOp(0, 32'd2, 1'b0, 1'b0, rd, ra, ri, ac, rc, to);
    checks++; if (to || rd !== 32'h0000_0001 || ra !== 32'h0000_0001) begin errors++; $display("[TB] FAIL wrap_data: got data %h acc %h expected 00000001", rd, ra); end
  endtask

  task automatic test_backpressure();
    bit got, seen;
    got = 0; seen = 0;
    rsp_ready = 1'b0;
    req_data[0*WIDTH +: WIDTH] = 32'd3;
    req_valid[0] = 1'b1;
    for (int n = 0; n < 20 && !got; n++) begin
      #1;
      if (req_ready[0]) got = 1;
      @(posedge clk);
      #1;
    end
    req_valid[0] = 1'b0;
    req_data[1*WIDTH +: WIDTH] = 32'd0;
    req_valid[1] = 1'b1;
    for (int n = 0; n < 20 && got && !seen; n++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("[TB] FAIL stall_timeout: no response within bound, expected one");
    end else begin
      checks++; if (rsp_data !== 32'd4 || rsp_accum !== 32'd4 || rsp_id !== 1'b0) begin errors++; $display("[TB] FAIL stall_first: got data %0d acc %0d id %0d expected 4 4 0", rsp_data, rsp_accum, rsp_id); end
      for (int i = 0; i < 4; i++) begin
        @(posedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd4 || rsp_accum !== 32'd4 || rsp_id !== 1'b0) begin errors++; $display("[TB] FAIL stall_hold[%0d]: got valid %b data %0d acc %0d id %0d expected 1 4 4 0", i, rsp_valid, rsp_data, rsp_accum, rsp_id); end
        checks++; if (req_ready !== 2'b00 || busy !== 1'b1) begin errors++; $display("[TB] FAIL stall_ctrl[%0d]: got req_ready %b busy %b expected 00 1", i, req_ready, busy); end
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_release: got rsp_valid %b expected 0", rsp_valid); end
      checks++; if (req_ready !== 2'b10) begin errors++; $display("[TB] FAIL stall_next_grant: got %b expected 10", req_ready); end
    end
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 32'd38) begin errors++; $display("[TB] FAIL stall_follow: got valid %b id %0d data %0d expected 1 1 38", rsp_valid, rsp_id, rsp_data); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_op();
    bit got, to;
    got = 0;
    rsp_ready = 1'b1;
    req_data[0*WIDTH +: WIDTH] = 32'd5;
    req_valid[0] = 1'b1;
    for (int n = 0; n < 20 && !got; n++) begin
      #1;
      if (req_ready[0]) got = 1;
      @(posedge clk);
      #1;
    end
    req_valid[0] = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midrst_exec_busy: got %b expected 1", busy); end
    rst_n = 1'b0;
    #2;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_async: got valid %b busy %b expected 0 0", rsp_valid, busy); end
    checks++; if (rsp_data !== 32'd0 || rsp_accum !== 32'd0 || rsp_id !== 1'b0) begin errors++; $display("[TB] FAIL midrst_rsp: got data %0d acc %0d id %0d expected 0 0 0", rsp_data, rsp_accum, rsp_id); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_data = {32'd4, 32'd4};
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("[TB] FAIL midrst_first_grant: got %b expected 01", req_ready); end
    collectRsp(2, to);
    checks++;
    if (to) begin
      errors++; $display("[TB] FAIL midrst_timeout: fewer than 2 responses, expected 2");
    end else begin
      checks++; if (gotId[0] !== 1'b0 || gotAcc[0] !== 32'd4) begin errors++; $display("[TB] FAIL midrst_ctx0: got id %0d acc %0d expected 0 4", gotId[0], gotAcc[0]); end
      checks++; if (gotId[1] !== 1'b1 || gotAcc[1] !== 32'd4) begin errors++; $display("[TB] FAIL midrst_ctx1: got id %0d acc %0d expected 1 4", gotId[1], gotAcc[1]); end
    end
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    test_reset();
    test_single_accum();
    test_round_robin();
    test_bypass();
    test_clear_wrap();
    test_backpressure();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
